// File: rtl/dma_regs_pkg.sv
// dma_regs_pkg
//   Shared definitions for the multi-channel DMA AXI4-Lite register slave:
//   per-channel word offsets, CTRL/STATUS bit positions, channel stride,
//   AXI response codes, write/read FSM state encodings and a byte-strobe
//   merge helper.
//   Optional feature macro used by the files importing this package: DMA_IRQ_EN.
package dma_regs_pkg;

  // Channel c lives at byte address c*0x20, so the channel index starts at bit 5.
  localparam int CH_STRIDE_LSB = 5;

  // Word index (address bits [4:2]) of each register inside a channel.
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_SRC    = 3'd2;
  localparam logic [2:0] OFF_DST    = 3'd3;
  localparam logic [2:0] OFF_LEN    = 3'd4;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_DONE_BIT   = 0;
  localparam int STAT_BUSY_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// dma_ch_regs
//   One DMA channel's register file: SRC/DST/LEN descriptors, CTRL (START
//   pulse, IRQ_EN when DMA_IRQ_EN is defined), sticky DONE/ERR status with
//   write-1-to-clear, busy lockout and the channel's interrupt term.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en               commit strobe for a write decoded to this channel
//   wr_off/data/strb    register word offset, write data, byte strobes
//   i_busy/done/err     engine status (level / pulse / pulse)
//   wr_reject           write would be dropped by busy lockout (SLVERR)
//   src_addr/dst_addr/trf_len  descriptor outputs
//   irq_en, done, err   readback of CTRL/STATUS state
//   start               one-cycle start pulse
//   irq_term            this channel's contribution to the interrupt
module dma_ch_regs
  import dma_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        i_busy,
  input  logic        i_done,
  input  logic        i_err,
  output logic        wr_reject,
  output logic [31:0] src_addr,
  output logic [31:0] dst_addr,
  output logic [31:0] trf_len,
  output logic        irq_en,
  output logic        done,
  output logic        err,
  output logic        start,
  output logic        irq_term
);

  logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic        done_q, done_d, err_q, err_d, start_q, start_d;
  logic        wr_ok, start_req, len_zero, done_clr, err_clr;

  always_comb begin
    // Descriptor writes and START are refused while the engine owns the channel.
    wr_reject = i_busy & ((wr_off == OFF_SRC) | (wr_off == OFF_DST) | (wr_off == OFF_LEN) |
                          ((wr_off == OFF_CTRL) & wr_data[CTRL_START_BIT]));
    wr_ok     = wr_en & ~wr_reject;
    start_req = wr_ok & (wr_off == OFF_CTRL) & wr_data[CTRL_START_BIT];
    len_zero  = (len_q == 32'd0);

    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (wr_ok && wr_off == OFF_SRC) src_d = apply_wstrb(src_q, wr_data, wr_strb);
    if (wr_ok && wr_off == OFF_DST) dst_d = apply_wstrb(dst_q, wr_data, wr_strb);
    if (wr_ok && wr_off == OFF_LEN) len_d = apply_wstrb(len_q, wr_data, wr_strb);

    start_d  = start_req & ~len_zero;
    // A new start clears stale status; W1C clears selected bits.
    done_clr = start_d | (wr_ok & (wr_off == OFF_STATUS) & wr_data[STAT_DONE_BIT]);
    err_clr  = start_d | (wr_ok & (wr_off == OFF_STATUS) & wr_data[STAT_ERR_BIT]);
    // Hardware set is OR-ed in last so it beats a simultaneous clear.
    done_d   = (done_q & ~done_clr) | i_done;
    err_d    = (err_q & ~err_clr) | i_err | (start_req & len_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign src_addr = src_q;
  assign dst_addr = dst_q;
  assign trf_len  = len_q;
  assign done     = done_q;
  assign err      = err_q;
  assign start    = start_q;

`ifdef DMA_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ok && wr_off == OFF_CTRL) irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
  end

  always_ff @(posedge clk) begin
    if (rst) irq_en_q <= 1'b0;
    else     irq_en_q <= irq_en_d;
  end

  assign irq_en   = irq_en_q;
  assign irq_term = irq_en_q & (done_q | err_q);
`else
  assign irq_en   = 1'b0;
  assign irq_term = 1'b0;
`endif

endmodule

// File: rtl/dma_multi_ch_axil_regs.sv
// dma_multi_ch_axil_regs
//   AXI4-Lite register slave for an NUM_CH-channel DMA engine. Holds the
//   AXI write/read FSMs, address decode and read mux; per-channel state
//   lives in dma_ch_regs instances. Channel c is at byte base c*0x20.
//   Optional macro DMA_IRQ_EN enables the registered level interrupt o_irq
//   and CTRL.IRQ_EN; without it o_irq is tied low.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*/AR*/R*     AXI4-Lite slave (PROT ignored)
//   o_src_addr/o_dst_addr/o_trf_len  per-channel descriptors, [c*32 +: 32]
//   o_dma_start                one-cycle start pulse per channel
//   i_dma_busy/done/err        per-channel engine status
//   o_irq                      level interrupt
module dma_multi_ch_axil_regs
  import dma_regs_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH*32-1:0]            o_src_addr,
  output logic [NUM_CH*32-1:0]            o_dst_addr,
  output logic [NUM_CH*32-1:0]            o_trf_len,
  output logic [NUM_CH-1:0]               o_dma_start,
  input  logic [NUM_CH-1:0]               i_dma_busy,
  input  logic [NUM_CH-1:0]               i_dma_done,
  input  logic [NUM_CH-1:0]               i_dma_err,
  output logic                            o_irq
);

  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int CH_W = AW - CH_STRIDE_LSB;

  wr_state_e           wr_state_q, wr_state_d;
  rd_state_e           rd_state_q, rd_state_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AW-1:0]       awaddr_q, awaddr_d;
  logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DW/8-1:0]     wstrb_q, wstrb_d;

  logic                aw_hs, w_hs, ar_hs, commit, wr_slverr;
  logic [AW-1:0]       cm_addr;
  logic [DW-1:0]       cm_data;
  logic [DW/8-1:0]     cm_strb;
  logic [CH_W-1:0]     wr_ch, ar_ch;
  logic [2:0]          wr_off, ar_off;
  logic [NUM_CH-1:0]   wr_sel, wr_en, ch_reject, ch_irq_en, ch_done, ch_err, ch_irq_term;
  logic [31:0]         ch_src [NUM_CH];
  logic [31:0]         ch_dst [NUM_CH];
  logic [31:0]         ch_len [NUM_CH];
  logic [31:0]         rd_word;
  logic [1:0]          rd_resp;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // The commit uses whichever half was captured earlier plus the half on the bus now.
  assign cm_addr = (wr_state_q == W_DATA) ? awaddr_q : S_AXI_AWADDR;
  assign cm_data = (wr_state_q == W_ADDR) ? wdata_q  : S_AXI_WDATA;
  assign cm_strb = (wr_state_q == W_ADDR) ? wstrb_q  : S_AXI_WSTRB;
  assign commit  = ((wr_state_q == W_IDLE) & aw_hs & w_hs) |
                   ((wr_state_q == W_DATA) & w_hs) |
                   ((wr_state_q == W_ADDR) & aw_hs);

  assign wr_ch     = cm_addr[AW-1:CH_STRIDE_LSB];
  assign wr_off    = cm_addr[4:2];
  assign ar_ch     = S_AXI_ARADDR[AW-1:CH_STRIDE_LSB];
  assign ar_off    = S_AXI_ARADDR[4:2];
  assign wr_en     = wr_sel & {NUM_CH{commit}};
  // Out-of-range channels select nothing, so they cannot touch any register.
  assign wr_slverr = (int'(wr_ch) >= NUM_CH) | (|(ch_reject & wr_sel));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel[c] = (wr_ch == CH_W'(c));

    dma_ch_regs u_ch (
      .clk       (S_AXI_ACLK),
      .rst       (S_AXI_ARESET),
      .wr_en     (wr_en[c]),
      .wr_off    (wr_off),
      .wr_data   (cm_data),
      .wr_strb   (cm_strb),
      .i_busy    (i_dma_busy[c]),
      .i_done    (i_dma_done[c]),
      .i_err     (i_dma_err[c]),
      .wr_reject (ch_reject[c]),
      .src_addr  (ch_src[c]),
      .dst_addr  (ch_dst[c]),
      .trf_len   (ch_len[c]),
      .irq_en    (ch_irq_en[c]),
      .done      (ch_done[c]),
      .err       (ch_err[c]),
      .start     (o_dma_start[c]),
      .irq_term  (ch_irq_term[c])
    );

    assign o_src_addr[c*32 +: 32] = ch_src[c];
    assign o_dst_addr[c*32 +: 32] = ch_dst[c];
    assign o_trf_len[c*32 +: 32]  = ch_len[c];
  end

  // Write FSM
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (wr_state_q)
      W_IDLE: begin
        // Readies come up here on the first cycle out of reset.
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && !w_hs) begin
          awaddr_d   = S_AXI_AWADDR;
          awready_d  = 1'b0;
          wr_state_d = W_DATA;
        end else if (w_hs && !aw_hs) begin
          wdata_d    = S_AXI_WDATA;
          wstrb_d    = S_AXI_WSTRB;
          wready_d   = 1'b0;
          wr_state_d = W_ADDR;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: ;
    endcase
    if (commit) begin
      bvalid_d   = 1'b1;
      bresp_d    = wr_slverr ? RESP_SLVERR : RESP_OKAY;
      awready_d  = 1'b0;
      wready_d   = 1'b0;
      wr_state_d = W_RESP;
    end
  end

  // Read mux: unmapped channels give SLVERR/0, reserved offsets give OKAY/0.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ar_ch == CH_W'(c)) begin
        rd_resp = RESP_OKAY;
        case (ar_off)
          OFF_CTRL:   rd_word[CTRL_IRQ_EN_BIT] = ch_irq_en[c];
          OFF_STATUS: begin
            rd_word[STAT_DONE_BIT] = ch_done[c];
            rd_word[STAT_BUSY_BIT] = i_dma_busy[c];
            rd_word[STAT_ERR_BIT]  = ch_err[c];
          end
          OFF_SRC:    rd_word = ch_src[c];
          OFF_DST:    rd_word = ch_dst[c];
          OFF_LEN:    rd_word = ch_len[c];
          default:    ;
        endcase
      end
    end
  end

  // Read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d    = rd_word;
          rresp_d    = rd_resp;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |ch_irq_term;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_q <= 1'b0;
    else              irq_q <= irq_d;
  end

  assign o_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^ch_irq_term;
  assign o_irq      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, cm_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_dma_multi_ch_axil_regs.sv
module tb_dma_multi_ch_axil_regs;

`ifdef DMA_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] o_src_addr, o_dst_addr, o_trf_len;
  logic [3:0]   o_dma_start, i_dma_busy, i_dma_done, i_dma_err;
  logic         o_irq;

  int          n_chk = 0;
  int          n_err = 0;
  int          start_cnt [4];
  logic [3:0]  last_start;
  logic        last_irq;
  logic [1:0]  resp;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dma_multi_ch_axil_regs #(.NUM_CH(4), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr), .o_trf_len(o_trf_len),
    .o_dma_start(o_dma_start), .i_dma_busy(i_dma_busy), .i_dma_done(i_dma_done),
    .i_dma_err(i_dma_err), .o_irq(o_irq)
  );

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (o_dma_start[c]) start_cnt[c] = start_cnt[c] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) check("b_timeout", 32'(bvalid), 32'd1);
    r          = bresp;
    last_start = o_dma_start;
    last_irq   = o_irq;
    bready     = 1'b1;
    @(negedge clk);
    bready     = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    logic a_done, w_done, a_hs, w_hs;
    int n;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    a_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(a_done && w_done) && n < 20) begin
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(negedge clk);
      if (a_hs) begin a_done = 1'b1; awvalid = 1'b0; end
      if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(a_done && w_done)) check("wr_hs_timeout", 32'(a_done & w_done), 32'd1);
    wait_b(r);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) check("r_timeout", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int hold_ok;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    i_dma_busy = '0; i_dma_done = '0; i_dma_err = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_start", 32'(o_dma_start), 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    check("rst_src0", o_src_addr[31:0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_arready", 32'(arready), 32'd1);

    // Program and start channel 2
    axi_write(8'h48, 32'h1000_0000, 4'hF, resp); check("ch2_src_resp", 32'(resp), 32'd0);
    axi_write(8'h4C, 32'h2000_0000, 4'hF, resp);
    axi_write(8'h50, 32'h0000_0040, 4'hF, resp);
    axi_write(8'h40, 32'h0000_0001, 4'hF, resp);
    check("ch2_ctrl_resp", 32'(resp), 32'd0);
    check("ch2_start_vec", 32'(last_start), 32'h4);
    repeat (3) @(negedge clk);
    check("ch2_start_once", 32'(start_cnt[2]), 32'd1);
    check("start_idle", 32'(o_dma_start), 32'd0);
    check("ch2_src_port", o_src_addr[95:64], 32'h1000_0000);
    axi_read(8'h48, rd, resp); check("ch2_src_rd", rd, 32'h1000_0000);
    axi_read(8'h4C, rd, resp); check("ch2_dst_rd", rd, 32'h2000_0000);
    axi_read(8'h50, rd, resp); check("ch2_len_rd", rd, 32'h40);
    axi_read(8'h40, rd, resp); check("ch2_ctrl_rd", rd, 32'h0);
    axi_read(8'h44, rd, resp); check("ch2_stat_rd", rd, 32'h0);

    // Split AW / W with partial strobes
    axi_write(8'h08, 32'h1122_3344, 4'hF, resp);
    @(negedge clk); awaddr = 8'h08; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    check("split_awready_low", 32'(awready), 32'd0);
    repeat (2) @(negedge clk);
    check("split_bvalid_pre", 32'(bvalid), 32'd0);
    check("split_wready", 32'(wready), 32'd1);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0011; wvalid = 1'b1;
    @(negedge clk); wvalid = 1'b0;
    check("split_bvalid", 32'(bvalid), 32'd1);
    hold_ok = 0;
    repeat (5) begin
      @(negedge clk);
      if (bvalid === 1'b1 && bresp === 2'b00) hold_ok++;
    end
    check("b_hold", 32'(hold_ok), 32'd5);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    check("b_released", 32'(bvalid), 32'd0);
    axi_read(8'h08, rd, resp); check("ch0_src_strb", rd, 32'h1122_CCDD);

    // Busy lockout and zero-length start on channel 1
    @(negedge clk); i_dma_busy = 4'b0010;
    axi_write(8'h30, 32'h80, 4'hF, resp); check("busy_len_resp", 32'(resp), 32'd2);
    axi_write(8'h20, 32'h1, 4'hF, resp);  check("busy_start_resp", 32'(resp), 32'd2);
    check("busy_no_pulse", 32'(last_start), 32'd0);
    axi_read(8'h30, rd, resp); check("busy_len_kept", rd, 32'h0);
    axi_read(8'h24, rd, resp); check("busy_stat", rd, 32'h2);
    @(negedge clk); i_dma_busy = 4'b0000;
    axi_write(8'h20, 32'h1, 4'hF, resp); check("len0_resp", 32'(resp), 32'd0);
    check("len0_no_pulse", 32'(last_start), 32'd0);
    axi_read(8'h24, rd, resp); check("len0_err", rd, 32'h4);
    check("ch1_start_cnt", 32'(start_cnt[1]), 32'd0);

    // Interrupt on channel 3
    axi_write(8'h60, 32'h2, 4'hF, resp);
    axi_read(8'h60, rd, resp); check("ch3_ctrl_rd", rd, {30'b0, IRQ_ON, 1'b0});
    @(negedge clk); i_dma_done = 4'b1000;
    @(negedge clk); i_dma_done = 4'b0000;
    check("irq_lag", 32'(o_irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(o_irq), 32'(IRQ_ON));
    axi_read(8'h64, rd, resp); check("ch3_done", rd, 32'h1);
    // W1C on the same edge as a fresh done pulse
    @(negedge clk);
    awaddr = 8'h64; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; i_dma_done = 4'b1000;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; i_dma_done = 4'b0000;
    check("w1c_race_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    axi_read(8'h64, rd, resp); check("w1c_race_done", rd, 32'h1);
    check("irq_held", 32'(o_irq), 32'(IRQ_ON));
    axi_write(8'h64, 32'h1, 4'hF, resp);
    check("irq_clr_lag", 32'(last_irq), 32'(IRQ_ON));
    check("irq_clr", 32'(o_irq), 32'd0);
    axi_read(8'h64, rd, resp); check("ch3_cleared", rd, 32'h0);

    // Out-of-range channel and reserved offset
    axi_read(8'h80, rd, resp);
    check("oor_rresp", 32'(resp), 32'd2);
    check("oor_rdata", rd, 32'h0);
    axi_write(8'h88, 32'hDEAD_BEEF, 4'hF, resp); check("oor_bresp", 32'(resp), 32'd2);
    check("oor_src0", o_src_addr[31:0], 32'h1122_CCDD);
    check("oor_src2", o_src_addr[95:64], 32'h1000_0000);
    axi_read(8'h54, rd, resp);
    check("rsvd_rresp", 32'(resp), 32'd0);
    check("rsvd_rdata", rd, 32'h0);

    // Reset between AW and W
    @(negedge clk); awaddr = 8'h0C; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    check("mid_awready", 32'(awready), 32'd0);
    rst = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_wready", 32'(wready), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_src0", o_src_addr[31:0], 32'd0);
    check("mid_rst_dst0", o_dst_addr[31:0], 32'd0);
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mid_rel_awready", 32'(awready), 32'd1);
    check("mid_rel_bvalid", 32'(bvalid), 32'd0);
    axi_read(8'h0C, rd, resp); check("mid_no_commit", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_multi_ch_axil_regs.md
# dma_multi_ch_axil_regs

Parametrised AXI4-Lite control/status register slave for a multi-channel DMA engine, the successor to the single-channel DMA register slave. The CPU programs per-channel source, destination and length, and fires a one-cycle start pulse per channel. Each channel has sticky done/error status with write-1-to-clear and a busy lockout that protects live descriptors. An optional level interrupt is driven to the CPU. Sits between the CPU interconnect and the DMA read/write master cores.

## Interface
- NUM_CH, 4, number of DMA channels (1..8)
- C_S_AXI_DATA_WIDTH, 32, fixed at 32
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must be ≥ 5 + clog2(NUM_CH)

- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave channels; AWPROT/ARPROT ignored
- o_src_addr  out  NUM_CH*32  channel c at [c*32 +: 32]
- o_dst_addr  out  NUM_CH*32  same packing
- o_trf_len  out  NUM_CH*32  byte count, same packing
- o_dma_start  out  NUM_CH  one-cycle start pulse per channel
- i_dma_busy  in  NUM_CH  channel transfer in progress (level)
- i_dma_done  in  NUM_CH  completion pulse
- i_dma_err  in  NUM_CH  error pulse
- o_irq  out  1  level interrupt (see Configuration)

## Operation
- Address map: channel c at base c*0x20. Word offsets within a channel:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (R/W)
  - 0x04 STATUS: bit0 DONE (sticky, W1C); bit1 BUSY (RO, mirrors i_dma_busy); bit2 ERR (sticky, W1C)
  - 0x08 SRC, 0x0C DST, 0x10 LEN: R/W with WSTRB byte enables
  - 0x14–0x1C: reserved; reads return 0, writes are ignored, response OKAY
- Decode:
  - Channel index ≥ NUM_CH → SLVERR; reads return 0; no state change.
  - Address bits [1:0] are ignored.
- Busy lockout: a write to SRC/DST/LEN, or START=1, while i_dma_busy[c]=1 is dropped and answered with SLVERR.
- Start:
  - START=1 with LEN≠0 and not busy → o_dma_start[c]=1 for exactly one cycle, and DONE/ERR of c are cleared.
  - START=1 with LEN=0 → no pulse, ERR set, response OKAY.
- Status:
  - i_dma_done[c] sets DONE; i_dma_err[c] sets ERR.
  - If a hardware set and a W1C clear hit the same bit in the same cycle, the set wins.
- Write FSM (W_IDLE, W_ADDR, W_DATA, W_RESP):
  - In W_IDLE, AWREADY=WREADY=1.
  - AW and W are captured independently. If only one arrives, its ready drops and the FSM waits (W_DATA or W_ADDR) for the other.
  - With both captured, the write commits and BVALID rises. In W_RESP, both readies are 0.
  - BVALID and BRESP hold until BREADY, then return to W_IDLE.
- Read FSM (R_IDLE, R_DATA):
  - ARREADY=1 in R_IDLE.
  - On the AR handshake, RDATA/RRESP are registered from the captured address, RVALID=1 and ARREADY=0.
  - RDATA holds stable until the RVALID&RREADY handshake.
- Reads and writes proceed concurrently. A read of STATUS reflects the value at the AR-handshake edge.

## Timing
- Reset values:
  - AWREADY/WREADY/ARREADY/BVALID/RVALID = 0; BRESP/RRESP = 00; RDATA = 0.
  - All registers = 0; o_dma_start = 0; o_irq = 0.
  - The readies rise on the first cycle after reset deasserts.
- Reset mid-transaction: outstanding handshakes are abandoned and no write commits.
- Write latency:
  - AW and W in the same cycle → BVALID on the next edge.
  - Split AW/W → BVALID one cycle after the later handshake.
- Register outputs update on the same edge that BVALID rises.
- o_dma_start pulses on the cycle after the commit edge.
- Read latency: RVALID one cycle after the AR handshake. Back-to-back reads run at 1 per 2 cycles.
- o_irq is registered: it reflects a status change one cycle after the status update.

## Configuration
- DMA_IRQ_EN defined:
  - o_irq = OR over c of IRQ_EN[c] & (DONE[c] | ERR[c]).
  - The interrupt deasserts one cycle after the W1C that clears the last pending source.
- DMA_IRQ_EN undefined:
  - o_irq is tied to 0.
  - CTRL bit1 is not implemented: it reads 0 and writes to it are ignored.
  - All other behaviour is unchanged.

## Structure
- Package dma_regs_pkg holds:
  - register word offsets, CTRL/STATUS bit positions and the channel stride
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - write/read FSM state enums
- Sub-module dma_ch_regs is instantiated NUM_CH times. Each instance holds:
  - one channel's registers, busy lockout and start-pulse logic
  - sticky status and the per-channel IRQ term
- The top level holds the AXI FSMs, decode and read mux.

## Test plan
- Program ch2: SRC=0x1000_0000, DST=0x2000_0000, LEN=0x40, then CTRL=0x1 → o_dma_start=4'b0100 for one cycle; readback of all three registers matches.
- AW then W three cycles later, writing WSTRB=4'b0011, WDATA=0xAABBCCDD to ch0 SRC (previously 0x11223344) → reads 0x1122CCDD; BVALID one cycle after the W handshake; BREADY held low for five cycles keeps BVALID/BRESP stable.
- Hold i_dma_busy[1]=1 and write LEN=0x80 plus START to ch1 → both SLVERR, LEN unchanged, no pulse. Start ch1 with LEN=0 → ERR=1, no pulse.
- With IRQ_EN[3]=1, pulse i_dma_done[3] → STATUS=0x1 and o_irq=1 next cycle. Write STATUS=0x1 in the same cycle as a second done pulse → DONE stays 1. A later clear drops o_irq one cycle after.
- Read 0x80 with NUM_CH=4 → RRESP=SLVERR, RDATA=0; write there → SLVERR, no register changed.
- Assert S_AXI_ARESET between the AW and W handshakes → no commit, all outputs at reset values; AWREADY=1 one cycle after release.
